decoder_n_seq: RTL
==================

# decoder_n_seq

Parametrised, registered binary-to-one-hot decoder with an active-low enable and two modes. In direct mode it decodes a strobed select. In scan mode it steps its own index through every output with a programmable dwell time. It drives chip-select, LED-row and mux-strobe fan-out in the DECODER family. Outputs are registered so downstream logic sees glitch-free one-hot lines.

## Interface
- SEL_W, 3: select width; output count N = 2**SEL_W (3 gives 8 outputs).
- DWELL_W, 4: width of the scan dwell count.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en_n  in  1  active-low enable; 1 forces outputs inactive and freezes state.
- mode  in  1  0 = DIRECT, 1 = SCAN.
- valid  in  1  DIRECT-mode strobe; sel is captured when valid=1.
- sel  in  SEL_W  DIRECT-mode select.
- dwell  in  DWELL_W  SCAN mode: each output is held for dwell+1 cycles.
- y  out  N  registered one-hot output; all zeros when inactive.
- y_valid  out  1  1 when y holds a valid one-hot code.
- index  out  SEL_W  binary index of the currently or last selected output.
- wrap  out  1  one-cycle pulse when the scan index wraps from N-1 to 0.

## Operation
- States:
  - DISABLED: en_n=1, or no select captured yet since reset.
  - DIRECT: en_n=0, mode=0.
  - SCAN: en_n=0, mode=1.
- Reset, which wins over every other input, sets y=0, y_valid=0, index=0, wrap=0, dwell counter=0 and state DISABLED.
- DIRECT mode:
  - valid=1 with en_n=0: on the next edge, index=sel, y=1<<sel and y_valid=1.
  - valid=0: y, index and y_valid hold. The decode is latched, not pulsed.
  - After reset, y stays 0 until the first valid strobe.
- SCAN mode:
  - valid and sel are ignored.
  - The dwell counter counts from 0 up to the captured dwell. When it reaches that value, index increments, the counter returns to 0 and a new dwell is captured.
  - dwell is sampled only at the start of each dwell period. Mid-period changes take effect at the next step.
  - Index N-1 steps to 0, and wrap=1 for exactly the cycle in which y first shows output 0.
  - dwell=0 advances the index every cycle.
- Mode switches:
  - DIRECT to SCAN: scanning starts from the current index and the dwell counter clears to 0. If no select has been captured, scanning starts at index 0.
  - SCAN to DIRECT: y holds the current scan output until the next valid strobe.
- en_n=1:
  - On the next edge, y=0 and y_valid=0.
  - index and the captured dwell are frozen, and the dwell counter clears.
  - wrap is held at 0 while disabled.
- en_n returning to 0: on the next edge y=1<<index, y_valid=1 in either mode. Scan resumes with a full dwell period at the same index.
- Invariant: y is always all-zeros or exactly one-hot. When y_valid=1, y == 1<<index.

## Timing
- DIRECT latency: 1 cycle from sel/valid to y.
- SCAN: each output is asserted for exactly dwell+1 consecutive cycles while enabled. One full sweep takes N*(dwell+1) cycles.
- wrap is high for 1 cycle per sweep, aligned with y[0] rising in SCAN.
- Simultaneous events resolve in this priority order: rst > en_n=1 > mode > valid.
- Reset asserted mid-scan takes effect at that edge. The sweep restarts at index 0 only after a later enable in SCAN mode.
- All outputs come directly from flops, with no combinational path from input to output.

## Structure
- Shared package decoder_pkg holds:
  - MODE_DIRECT=1'b0 and MODE_SCAN=1'b1.
  - State encoding DISABLED, DIRECT, SCAN.
  - A function computing N from SEL_W.
- Sub-module onehot_dec: a purely combinational SEL_W-to-N decoder with an active-low enable. This generalises the team's fixed 3-to-8 decoder. It is instantiated once, feeding the y register.
- The top level holds the state register, index counter, dwell counter and captured-dwell register.

## Test plan
- Reset, then en_n=0, mode=0, valid=1, sel=5 → y=8'b0010_0000, y_valid=1 and index=5 on the next cycle. Then valid=0 with sel=2 → y unchanged.
- SCAN with dwell=2 from index 0 → each of y[0]..y[7] is high for 3 cycles. wrap is pulsed once, 24 cycles after scan start, with y=8'b0000_0001.
- SCAN with dwell=0 → index 7 → 0 on consecutive cycles, and wrap=1 on the cycle showing 0.
- Mid-scan at index 3, en_n=1 for 5 cycles → y=0 and y_valid=0. On re-enable, y=8'b0000_1000 for a full dwell+1 cycles.
- Same edge with rst=1, en_n=0, valid=1, sel=6 → y=0, index=0. Same edge with en_n=1 and valid=1 → no capture.
- With SEL_W=4, sweep sel 0..15 in DIRECT mode → y is one-hot at bit sel every time. An assertion checks $onehot0(y) throughout.

Source files
------------

// File: rtl/decoder_pkg.sv
// decoder_pkg
// Shared definitions for the DECODER family: mode encodings, the sequencer
// state type and a helper that turns a select width into an output count.
package decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    DIRECT   = 2'd1,
    SCAN     = 2'd2
  } state_t;

  function automatic int calcOutCount(input int selW);
    return 1 << selW;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// onehot_dec
// Purely combinational SEL_W-to-N one-hot decoder with an active-low enable.
// Ports:
//   i_sel   select index
//   i_en_n  active-low enable; 1 forces every output low
//   o_y     one-hot output, bit i_sel high when enabled
module onehot_dec
  import decoder_pkg::*;
#(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]                 i_sel,
  input  logic                             i_en_n,
  output logic [calcOutCount(SEL_W)-1:0]   o_y
);

  localparam int N = calcOutCount(SEL_W);

  always_comb begin
    o_y = '0;
    for (int i = 0; i < N; i++) begin
      o_y[i] = !i_en_n && (i_sel == SEL_W'(i));
    end
  end

endmodule

// File: rtl/decoder_n_seq.sv
// decoder_n_seq
// Registered binary-to-one-hot decoder with a strobed DIRECT mode and a
// self-stepping SCAN mode with programmable dwell. All outputs are flops.
// Ports:
//   i_clk, i_rst   rising-edge clock, synchronous active-high reset
//   i_en_n         active-low enable; 1 blanks outputs and freezes state
//   i_mode         0 = DIRECT, 1 = SCAN
//   i_valid, i_sel DIRECT-mode strobe and select
//   i_dwell        SCAN-mode dwell; each output held dwell+1 cycles
//   o_y            registered one-hot output (all zeros when inactive)
//   o_y_valid      o_y holds a valid one-hot code
//   o_index        binary index of the current / last selected output
//   o_wrap         one-cycle pulse when the scan wraps back to output 0
module decoder_n_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_en_n,
  input  logic                           i_mode,
  input  logic                           i_valid,
  input  logic [SEL_W-1:0]               i_sel,
  input  logic [DWELL_W-1:0]             i_dwell,
  output logic [calcOutCount(SEL_W)-1:0] o_y,
  output logic                           o_y_valid,
  output logic [SEL_W-1:0]               o_index,
  output logic                           o_wrap
);

  localparam int N = calcOutCount(SEL_W);

  state_t               r_state;
  state_t               w_stateNext;
  logic [N-1:0]         r_y;
  logic                 r_yValid;
  logic                 r_wrap;
  logic                 r_primed;
  logic [SEL_W-1:0]     r_index;
  logic [DWELL_W-1:0]   r_cnt;
  logic [DWELL_W-1:0]   r_dwell;

  logic                 w_yLoad;
  logic                 w_decEn_n;
  logic [SEL_W-1:0]     w_decSel;
  logic [N-1:0]         w_decY;
  logic                 w_yValidNext;
  logic                 w_wrapNext;
  logic                 w_primedNext;
  logic [SEL_W-1:0]     w_indexNext;
  logic [DWELL_W-1:0]   w_cntNext;
  logic [DWELL_W-1:0]   w_dwellNext;

  onehot_dec #(.SEL_W(SEL_W)) uDec (
    .i_sel  (w_decSel),
    .i_en_n (w_decEn_n),
    .o_y    (w_decY)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= DISABLED;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // DIRECT is only entered once something has been captured since reset
  // (r_primed); until then an enabled DIRECT request stays blanked.
  always_comb begin
    w_stateNext = r_state;
    if (i_en_n) begin
      w_stateNext = DISABLED;
    end else if (i_mode == MODE_SCAN) begin
      w_stateNext = SCAN;
    end else if (i_valid || r_primed) begin
      w_stateNext = DIRECT;
    end else begin
      w_stateNext = DISABLED;
    end
  end

  // Next-value logic for the datapath. The single decoder is steered to
  // whichever index is about to be shown; with w_decEn_n high it yields
  // zeros, which is how the blanked state is loaded.
  always_comb begin
    w_yLoad      = 1'b0;
    w_decEn_n    = 1'b1;
    w_decSel     = r_index;
    w_yValidNext = r_yValid;
    w_wrapNext   = 1'b0;
    w_primedNext = r_primed;
    w_indexNext  = r_index;
    w_cntNext    = r_cnt;
    w_dwellNext  = r_dwell;
    case (w_stateNext)
      DISABLED: begin
        w_yLoad      = 1'b1;
        w_yValidNext = 1'b0;
        w_cntNext    = '0;
      end
      DIRECT: begin
        w_cntNext = '0;
        if (i_valid) begin
          w_indexNext  = i_sel;
          w_decSel     = i_sel;
          w_decEn_n    = 1'b0;
          w_yLoad      = 1'b1;
          w_yValidNext = 1'b1;
          w_primedNext = 1'b1;
        end else if (r_state == DISABLED) begin
          // Re-enable: show the frozen index again.
          w_decEn_n    = 1'b0;
          w_yLoad      = 1'b1;
          w_yValidNext = 1'b1;
        end
      end
      SCAN: begin
        w_primedNext = 1'b1;
        w_yValidNext = 1'b1;
        if (r_state != SCAN) begin
          // Entry or resume: full dwell period at the current index.
          w_decEn_n   = 1'b0;
          w_yLoad     = 1'b1;
          w_cntNext   = '0;
          w_dwellNext = i_dwell;
        end else if (r_cnt == r_dwell) begin
          w_indexNext = r_index + SEL_W'(1);
          w_decSel    = r_index + SEL_W'(1);
          w_decEn_n   = 1'b0;
          w_yLoad     = 1'b1;
          w_cntNext   = '0;
          w_dwellNext = i_dwell;
          w_wrapNext  = (r_index == SEL_W'(N - 1));
        end else begin
          w_cntNext = r_cnt + DWELL_W'(1);
        end
      end
      default: begin
        w_yLoad      = 1'b1;
        w_yValidNext = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_y      <= '0;
      r_yValid <= 1'b0;
      r_wrap   <= 1'b0;
      r_primed <= 1'b0;
      r_index  <= '0;
      r_cnt    <= '0;
      r_dwell  <= '0;
    end else begin
      if (w_yLoad) begin
        r_y <= w_decY;
      end
      r_yValid <= w_yValidNext;
      r_wrap   <= w_wrapNext;
      r_primed <= w_primedNext;
      r_index  <= w_indexNext;
      r_cnt    <= w_cntNext;
      r_dwell  <= w_dwellNext;
    end
  end

  assign o_y       = r_y;
  assign o_y_valid = r_yValid;
  assign o_index   = r_index;
  assign o_wrap    = r_wrap;

endmodule
